// File: rtl/gpp_pkg.sv
// Shared definitions for the accumulator datapath: default width, ALU opcodes and
// the sequential ALU state encoding.
package gpp_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;
    localparam logic [3:0] OP_DIV = 4'hC;
    localparam logic [3:0] OP_MOD = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide datapath.
// Both run in lockstep on every step; the FSM picks whichever result it needs.
module seq_alu_muldiv
    import gpp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               last,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    logic [2*WIDTH-1:0] prod_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quot_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_shift = {rem_reg, quot_reg[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg    <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
        end else if (load) begin
            prod_reg    <= '0;
            mcand_reg   <= {{WIDTH{1'b0}}, operand_a};
            mplier_reg  <= operand_b;
            rem_reg     <= '0;
            quot_reg    <= operand_a;
            divisor_reg <= operand_b;
            cnt_reg     <= CNT_W'(WIDTH);
        end else if (step) begin
            if (mplier_reg[0]) begin
                prod_reg <= prod_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            if (!trial[WIDTH]) begin
                rem_reg  <= trial[WIDTH-1:0];
                quot_reg <= {quot_reg[WIDTH-2:0], 1'b1};
            end else begin
                rem_reg  <= rem_shift[WIDTH-1:0];
                quot_reg <= {quot_reg[WIDTH-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign last      = (cnt_reg == CNT_W'(1));
    assign product   = prod_reg;
    assign quotient  = quot_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU between the register file accumulator and X/Y outputs.
// Single-cycle ops finish one cycle after acceptance; MUL/DIV/MOD iterate WIDTH steps.
module seq_alu
    import gpp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             acc_write,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    alu_state_t         state_reg;
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;

    logic               iter_op;
    logic               accept;
    logic               load;
    logic               step;
    logic               last;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    logic [WIDTH-1:0]   b_eff;
    logic [3:0]         shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl_wide;
    logic [WIDTH:0]     shr_wide;
    logic               b_zero;
    logic [WIDTH-1:0]   val_next;
    logic               c_next;
    logic               v_next;
    logic               wr_result;
    logic               wr_flags;

    // A divide by zero never enters ITER; it resolves in the DONE cycle.
    assign iter_op = (opcode == OP_MUL) ||
                     (((opcode == OP_DIV) || (opcode == OP_MOD)) && (operand_b != '0));
    assign accept  = (state_reg == ST_IDLE) && start && !done;
    assign load    = accept && iter_op;
    assign step    = (state_reg == ST_ITER);

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .last      (last),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign b_eff    = ((op_reg == OP_INC) || (op_reg == OP_DEC)) ? WIDTH'(1) : b_reg;
    assign shamt    = b_reg[3:0];
    assign sum      = {1'b0, a_reg} + {1'b0, b_eff};
    assign diff     = {1'b0, a_reg} - {1'b0, b_eff};
    // The extra bit catches the last bit shifted out; it stays 0 for a zero shift.
    assign shl_wide = {1'b0, a_reg} << shamt;
    assign shr_wide = {a_reg, 1'b0} >> shamt;
    assign b_zero   = (b_reg == '0);

    always_comb begin
        val_next  = '0;
        c_next    = 1'b0;
        v_next    = 1'b0;
        wr_result = 1'b1;
        wr_flags  = 1'b1;
        case (op_reg)
            OP_ADD, OP_INC: begin
                val_next = sum[WIDTH-1:0];
                c_next   = sum[WIDTH];
                v_next   = (a_reg[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (val_next[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                val_next  = diff[WIDTH-1:0];
                c_next    = diff[WIDTH];
                v_next    = (a_reg[WIDTH-1] != b_eff[WIDTH-1]) &&
                            (val_next[WIDTH-1] != a_reg[WIDTH-1]);
                wr_result = (op_reg != OP_CMP);
            end
            OP_AND: val_next = a_reg & b_reg;
            OP_OR:  val_next = a_reg | b_reg;
            OP_XOR: val_next = a_reg ^ b_reg;
            OP_NOT: val_next = ~a_reg;
            OP_SHL: begin
                val_next = shl_wide[WIDTH-1:0];
                c_next   = shl_wide[WIDTH];
            end
            OP_SHR: begin
                val_next = shr_wide[WIDTH:1];
                c_next   = shr_wide[0];
            end
            OP_MUL: begin
                val_next = product[WIDTH-1:0];
                c_next   = |product[2*WIDTH-1:WIDTH];
                v_next   = c_next;
            end
            OP_DIV: begin
                val_next = b_zero ? '1 : quotient;
                v_next   = b_zero;
            end
            OP_MOD: begin
                val_next = b_zero ? a_reg : remainder;
                v_next   = b_zero;
            end
            default: begin
                wr_result = 1'b0;
                wr_flags  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc_write <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
        end else begin
            done      <= 1'b0;
            acc_write <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg    <= opcode;
                        a_reg     <= operand_a;
                        b_reg     <= operand_b;
                        busy      <= 1'b1;
                        state_reg <= iter_op ? ST_ITER : ST_DONE;
                    end
                end
                ST_ITER: begin
                    if (last) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    acc_write <= wr_result;
                    if (wr_result) begin
                        result <= val_next;
                    end
                    if (wr_flags) begin
                        flag_z <= (val_next == '0);
                        flag_n <= val_next[WIDTH-1];
                        flag_c <= c_next;
                        flag_v <= v_next;
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Multi-cycle ALU directly downstream of general_purpose_registers. Operand A comes from data_out_accumulator and operand B from data_out (X or Y). The result returns to the register file: the result drives data_in and acc_write drives reg_write_accumulator. Single-cycle logic and arithmetic ops run alongside iterative 16-cycle multiply, divide and modulo, under a start/busy/done handshake with the control unit.

Parameters:
WIDTH, 16, datapath width. Must match the register file.
CNT_W, 5, iteration counter width. Must be at least clog2(WIDTH)+1.

Ports:
clk  in  1  clock. One clock domain; all logic on the rising edge.
rst  in  1  reset. Synchronous, active-high.
start  in  1  request to begin an op; sampled only when busy=0.
opcode  in  4  operation select.
operand_a  in  WIDTH  first operand (accumulator).
operand_b  in  WIDTH  second operand (X/Y).
busy  out  1  high from the cycle after an accepted start until done is asserted.
done  out  1  one-cycle completion pulse.
result  out  WIDTH  registered result; held until the next done.
acc_write  out  1  pulses with done when result must be written to the accumulator.
flag_z  out  1  zero flag.
flag_n  out  1  negative flag (result MSB).
flag_c  out  1  carry/borrow flag.
flag_v  out  1  overflow / divide-by-zero flag.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While rst=1 at a rising edge, all of the following clear to 0: state (IDLE), busy, done, acc_write, result, all flags, counter and internal registers. Reset mid-operation aborts the op with no done pulse.
- Opcodes:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR.
  - 5 NOT a.
  - 6 SHL a by b[3:0], 7 SHR (logical) a by b[3:0].
  - 8 INC a, 9 DEC a.
  - A CMP (a-b, flags only).
  - B MUL (unsigned, low WIDTH bits kept).
  - C DIV (unsigned quotient), D MOD (unsigned remainder).
  - E, F illegal.
- States: IDLE, ITER, DONE.
  - IDLE + start=1: latch opcode and operands.
  - MUL, or DIV/MOD with b!=0: go to ITER, counter=WIDTH.
  - Any other op: compute and go to DONE.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per cycle, counter decrements; at counter=1 go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - Start accepted at edge N. Simple ops: done visible after edge N+1.
  - MUL, DIV, MOD: done after edge N+WIDTH+1 (17 cycles at default).
  - Next start is accepted in the cycle done is high at the earliest? No: it is accepted only once back in IDLE.
- Handshake:
  - start while busy=1 or done=1 is ignored and not queued.
  - Operands and opcode may change after acceptance without effect.
- acc_write=done for every legal opcode except CMP.
  - CMP: flags update, result unchanged.
  - Illegal opcode: done pulses; acc_write=0; result and flags unchanged.
- Flags update only on the done cycle.
  - Z = (value==0) and N = value MSB, where value is the computed value (a-b for CMP).
  - ADD/INC: C=carry out, V=signed overflow.
  - SUB/DEC/CMP: C=borrow (unsigned a<b), V=signed overflow.
  - Logic ops and NOT: C=0, V=0.
  - Shifts: C=last bit shifted out; C=0 when amount=0. V=0.
  - MUL: C=V=(upper WIDTH product bits !=0).
  - DIV/MOD: C=0, V=divide-by-zero.
- Divide by zero is detected at acceptance with latency 1, skipping ITER.
  - DIV returns all-ones; MOD returns a. V=1, Z and N from the returned value.
- Wrap-around: INC of 0xFFFF gives 0x0000 with C=1, Z=1. DEC of 0x0000 gives 0xFFFF with C=1, N=1.

Decomposition:
- Shared package gpp_pkg holds:
  - opcode localparams OP_ADD..OP_MOD;
  - ALU state encoding;
  - WIDTH default.
- One natural sub-module, seq_alu_muldiv: the iterative multiply/divide datapath (accumulator, remainder, quotient shift registers and counter), driven by a load/step interface from the seq_alu FSM.

Test Plan:
- ADD a=0x7FFF, b=0x0001 -> done one cycle after acceptance; result=0x8000, N=1, V=1, C=0, Z=0, acc_write=1.
- MUL a=0x0123, b=0x0045 -> done at cycle 17, result=0x4E6F, C=V=0. Then MUL 0x1000*0x0010 -> result=0x0000, Z=1, C=V=1.
- DIV a=0x1234, b=0x0010 -> 0x0123. MOD same operands -> 0x0004. Both at latency 17.
- DIV a=0x00AB, b=0x0000 -> latency 1, result=0xFFFF, V=1, N=1. MOD same operands -> result=0x00AB, V=1.
- CMP a=0x0005, b=0x0005 -> Z=1, C=0, acc_write=0, result keeps its prior value. Opcode 0xE -> done=1, acc_write=0, flags unchanged.
- Start MUL, pulse start again at cycle 3 (ignored), assert rst at cycle 5 -> no done. Next cycle busy=0, result=0, flags=0, and a following ADD 2+3 returns 0x0005.
